// File: rtl/refill_ctrl_if.sv
// refill_ctrl_if: AXI4 read-address/read-data channel bundle for the refill controller.
//   master modport: refill controller (drives AR, accepts R)
//   slave  modport: memory side (accepts AR, drives R)
interface refill_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );
    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/refill_ctrl.sv
// refill_ctrl: cache miss-refill controller (AXI4 line fetch -> data array, then tag store update).
//   clk, reset          : clock, asynchronous active-high reset
//   i_lookup_*, i_addr  : lookup result for the address being served (miss starts a refill)
//   axi                 : AXI4 AR/R channels (refill_ctrl_if.master)
//   o_data_*            : per-beat data array write, combinational with the accepted R beat
//   o_tag_*             : one-cycle tag store write {valid, tag}, valid cleared on error
//   o_busy, o_refill_done, o_refill_err, o_crit_valid : status
//   Optional macro REFILL_CWF_EN: critical-word-first (WRAP burst starting at the requested word).
module refill_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int TAG_WIDTH  = 3,
    parameter int SET_WIDTH  = 3,
    parameter int LINE_WIDTH = 4,
    parameter int NUM_WAYS   = 4,
    parameter int DATA_WIDTH = 32,
    localparam int BEATS     = (2 ** LINE_WIDTH) / (DATA_WIDTH / 8),
    localparam int BEAT_BITS = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_lookup_valid,
    input  logic                  i_hit,
    input  logic [NUM_WAYS-1:0]   i_way_select,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_busy,
    refill_ctrl_if.master         axi,
    output logic                  o_data_we,
    output logic [NUM_WAYS-1:0]   o_data_way,
    output logic [SET_WIDTH-1:0]  o_data_set,
    output logic [BEAT_BITS-1:0]  o_data_word,
    output logic [DATA_WIDTH-1:0] o_data_wdata,
    output logic                  o_tag_we,
    output logic [NUM_WAYS-1:0]   o_tag_way,
    output logic [SET_WIDTH-1:0]  o_tag_set,
    output logic [TAG_WIDTH:0]    o_tag_wdata,
    output logic                  o_refill_done,
    output logic                  o_refill_err,
    output logic                  o_crit_valid
);
    localparam int WORD_BITS = $clog2(DATA_WIDTH / 8);
    typedef enum logic [1:0] {IDLE, AR, R, TAG} state_t;
    state_t                r_state;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [SET_WIDTH-1:0]  r_set;
    logic [NUM_WAYS-1:0]   r_way;
    logic [BEAT_BITS-1:0]  r_word;
    logic [BEAT_BITS-1:0]  r_beat;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic                  r_rready;
    logic                  r_tag_we;
    logic [NUM_WAYS-1:0]   r_tag_way;
    logic [SET_WIDTH-1:0]  r_tag_set;
    logic [TAG_WIDTH:0]    r_tag_wdata;
    logic                  r_done;
    logic                  r_done_err;
    logic                  w_we;
    logic                  w_last_idx;
    logic                  w_final;
    logic                  w_err_next;
    logic [ADDR_WIDTH-1:0] w_araddr;
    logic [BEAT_BITS-1:0]  w_start;
    logic [1:0]            w_burst;
`ifdef REFILL_CWF_EN
    logic                  r_first;
    assign w_araddr     = i_addr & ~ADDR_WIDTH'((1 << WORD_BITS) - 1);
    assign w_start      = i_addr[LINE_WIDTH-1:WORD_BITS];
    assign w_burst      = 2'b10;
    assign o_crit_valid = w_we & r_first;
`else
    assign w_araddr     = i_addr & ~ADDR_WIDTH'((1 << LINE_WIDTH) - 1);
    assign w_start      = '0;
    assign w_burst      = 2'b01;
    assign o_crit_valid = 1'b0;
`endif
    // rready is only ever high in R, so it qualifies every accepted beat
    assign w_we       = r_rready & axi.rvalid;
    assign w_last_idx = (r_beat == BEAT_BITS'(BEATS - 1));
    assign w_final    = w_last_idx | axi.rlast;
    // rlast must coincide exactly with the last beat index; any mismatch or bad response is sticky
    assign w_err_next = r_err | (axi.rresp != 2'b00) | (w_last_idx != axi.rlast);
    assign o_busy        = r_busy;
    assign axi.arvalid   = r_arvalid;
    assign axi.araddr    = r_araddr;
    assign axi.arlen     = r_arlen;
    assign axi.arsize    = r_arsize;
    assign axi.arburst   = r_arburst;
    assign axi.rready    = r_rready;
    assign o_data_we     = w_we;
    assign o_data_way    = w_we ? r_way : '0;
    assign o_data_set    = w_we ? r_set : '0;
    assign o_data_word   = w_we ? r_word : '0;
    assign o_data_wdata  = w_we ? axi.rdata : '0;
    assign o_tag_we      = r_tag_we;
    assign o_tag_way     = r_tag_way;
    assign o_tag_set     = r_tag_set;
    assign o_tag_wdata   = r_tag_wdata;
    assign o_refill_done = r_done;
    assign o_refill_err  = r_done_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_set       <= '0;
            r_way       <= '0;
            r_word      <= '0;
            r_beat      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
            r_rready    <= 1'b0;
            r_tag_we    <= 1'b0;
            r_tag_way   <= '0;
            r_tag_set   <= '0;
            r_tag_wdata <= '0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
`ifdef REFILL_CWF_EN
            r_first     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (i_lookup_valid && !i_hit) begin
                    r_tag     <= i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    r_set     <= i_addr[LINE_WIDTH +: SET_WIDTH];
                    r_way     <= i_way_select;
                    r_word    <= w_start;
                    r_beat    <= '0;
                    r_err     <= 1'b0;
                    r_busy    <= 1'b1;
                    r_arvalid <= 1'b1;
                    r_araddr  <= w_araddr;
                    r_arlen   <= 8'(BEATS - 1);
                    r_arsize  <= 3'(WORD_BITS);
                    r_arburst <= w_burst;
`ifdef REFILL_CWF_EN
                    r_first   <= 1'b1;
`endif
                    r_state   <= AR;
                end
                AR: if (axi.arready) begin
                    r_arvalid <= 1'b0;
                    r_araddr  <= '0;
                    r_arlen   <= '0;
                    r_arsize  <= '0;
                    r_arburst <= '0;
                    r_rready  <= 1'b1;
                    r_state   <= R;
                end
                R: if (w_we) begin
                    r_word <= r_word + 1'b1;
                    r_beat <= r_beat + 1'b1;
                    r_err  <= w_err_next;
`ifdef REFILL_CWF_EN
                    r_first <= 1'b0;
`endif
                    if (w_final) begin
                        r_rready    <= 1'b0;
                        r_tag_we    <= 1'b1;
                        r_tag_way   <= r_way;
                        r_tag_set   <= r_set;
                        r_tag_wdata <= {~w_err_next, r_tag};
                        r_done      <= 1'b1;
                        r_done_err  <= w_err_next;
                        r_state     <= TAG;
                    end
                end
                TAG: begin
                    r_busy      <= 1'b0;
                    r_tag_we    <= 1'b0;
                    r_tag_way   <= '0;
                    r_tag_set   <= '0;
                    r_tag_wdata <= '0;
                    r_done      <= 1'b0;
                    r_done_err  <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_refill_ctrl.sv
// tb_refill_ctrl: directed plus randomized self-checking bench for refill_ctrl.
module tb_refill_ctrl;
    localparam int BEATS = 4;
`ifdef REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_lookup_valid = 1'b0;
    logic        i_hit = 1'b0;
    logic [3:0]  i_way_select = '0;
    logic [9:0]  i_addr = '0;
    logic        o_busy, o_data_we, o_tag_we, o_refill_done, o_refill_err, o_crit_valid;
    logic [3:0]  o_data_way, o_tag_way, o_tag_wdata;
    logic [2:0]  o_data_set, o_tag_set;
    logic [1:0]  o_data_word;
    logic [31:0] o_data_wdata;
    int n_chk = 0;
    int n_fail = 0;
    refill_ctrl_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) axi ();
    refill_ctrl dut (
        .clk(clk), .reset(reset),
        .i_lookup_valid(i_lookup_valid), .i_hit(i_hit), .i_way_select(i_way_select), .i_addr(i_addr),
        .o_busy(o_busy), .axi(axi),
        .o_data_we(o_data_we), .o_data_way(o_data_way), .o_data_set(o_data_set),
        .o_data_word(o_data_word), .o_data_wdata(o_data_wdata),
        .o_tag_we(o_tag_we), .o_tag_way(o_tag_way), .o_tag_set(o_tag_set), .o_tag_wdata(o_tag_wdata),
        .o_refill_done(o_refill_done), .o_refill_err(o_refill_err), .o_crit_valid(o_crit_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask
    task automatic quiet(input string tag);
        chk(tag, {axi.arvalid, axi.rready, o_busy, o_data_we, o_tag_we, o_refill_done, o_refill_err}, 0);
    endtask
    // One refill seen from the memory side. The expected outcome is derived from the address
    // and the planned beat pattern: words start at the requested word (CWF) or 0 and wrap mod 4,
    // the line ends at rlast or after 4 beats, and any bad response or misplaced rlast fails it.
    task automatic miss(input logic [9:0] addr, input logic [3:0] way, input int ar_wait,
                        input int last_at, input logic [7:0] resp, input int max_gap,
                        input int abort_at, input bit rand_data, output int done_t);
        int t, start, beats, gap;
        logic err;
        logic [9:0] exp_araddr;
        logic [31:0] d;
        exp_araddr = CWF ? addr - addr % 4 : addr - addr % 16;
        start = CWF ? int'(addr % 16) / 4 : 0;
        beats = (last_at >= 1 && last_at <= BEATS) ? last_at : BEATS;
        err = (last_at != BEATS);
        for (int j = 0; j < beats; j++) if (resp[2*j +: 2] != 2'b00) err = 1'b1;
        done_t = -1;
        @(negedge clk);
        i_lookup_valid = 1'b1; i_hit = 1'b0; i_addr = addr; i_way_select = way;
        t = 0;
        @(negedge clk);
        i_lookup_valid = 1'b0; i_addr = $urandom; i_way_select = $urandom;
        t = 1;
        for (int k = 0; k <= ar_wait; k++) begin
            axi.arready = (k == ar_wait);
            #1;
            chk("ar_valid", axi.arvalid, 1);
            chk("ar_addr", axi.araddr, exp_araddr);
            chk("ar_ctl", {axi.arlen, axi.arsize, axi.arburst}, {8'd3, 3'd2, CWF ? 2'b10 : 2'b01});
            chk("ar_busy", {o_busy, axi.rready, o_data_we}, 3'b100);
            @(negedge clk);
            t++;
        end
        axi.arready = 1'b0;
        #1;
        chk("r_enter", {axi.arvalid, axi.rready, o_busy}, 3'b011);
        for (int j = 0; j < beats; j++) begin
            if (j == abort_at) begin
                axi.rvalid = 1'b1; axi.rdata = $urandom;
                reset = 1'b1;
                #1;
                chk("abort_now", {axi.rready, o_data_we, o_busy, o_tag_we, axi.arvalid}, 0);
                @(negedge clk);
                reset = 1'b0;
                #1;
                quiet("abort_next");
                @(negedge clk);
                axi.rvalid = 1'b0;
                #1;
                quiet("abort_idle");
                return;
            end
            gap = max_gap > 0 ? int'($urandom_range(max_gap)) : 0;
            repeat (gap) begin
                axi.rvalid = 1'b0;
                #1;
                chk("r_gap", {axi.rready, o_data_we}, 2'b10);
                @(negedge clk);
                t++;
            end
            d = rand_data ? 32'($urandom) : 32'(32'h11 * (j + 1));
            axi.rvalid = 1'b1; axi.rdata = d; axi.rresp = resp[2*j +: 2];
            axi.rlast = (j + 1 == last_at);
            #1;
            chk("data_we", o_data_we, 1);
            chk("data_way_set", {o_data_way, o_data_set}, {way, addr[6:4]});
            chk("data_word", o_data_word, (start + j) % BEATS);
            chk("data_wdata", o_data_wdata, d);
            chk("crit_valid", o_crit_valid, CWF && j == 0);
            chk("no_tag_mid", {o_tag_we, o_refill_done}, 0);
            @(negedge clk);
            t++;
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        #1;
        chk("tag_we", o_tag_we, 1);
        chk("tag_way_set", {o_tag_way, o_tag_set}, {way, addr[6:4]});
        chk("tag_wdata", o_tag_wdata, {~err, addr[9:7]});
        chk("done_err", {o_refill_done, o_refill_err}, {1'b1, err});
        chk("tag_state", {o_busy, axi.rready, o_data_we}, 3'b100);
        done_t = t;
        @(negedge clk);
        #1;
        quiet("after_done");
    endtask
    task automatic hit(input logic [9:0] addr, input int cycles);
        @(negedge clk);
        i_lookup_valid = 1'b1; i_hit = 1'b1; i_addr = addr; i_way_select = 4'b0100;
        @(negedge clk);
        i_lookup_valid = 1'b0; i_hit = 1'b0;
        repeat (cycles) begin
            #1;
            quiet("hit_quiet");
            @(negedge clk);
        end
    endtask
    initial begin
        int dt;
        logic [9:0] a;
        logic [7:0] rs;
        int la;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", {o_busy, axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.rready,
                          o_data_we, o_data_way, o_data_set, o_data_word, o_tag_we, o_tag_way,
                          o_tag_set, o_tag_wdata, o_refill_done, o_refill_err, o_crit_valid}, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_reset", {o_busy, axi.arvalid, axi.araddr, axi.rready, o_data_wdata, o_tag_we}, 0);
        hit(10'h2A4, 10);
        miss(10'h2A4, 4'b0100, 0, 4, 8'h00, 0, -1, 1'b0, dt);
        chk("latency", dt, 6);
        miss(10'h2A4, 4'b0100, 0, 4, 8'b0000_1000, 0, -1, 1'b0, dt);
        miss(10'h2A4, 4'b0100, 5, 2, 8'h00, 0, -1, 1'b0, dt);
        miss(10'h2A4, 4'b0100, 0, 4, 8'h00, 0, 2, 1'b0, dt);
        chk("abort_no_done", dt, -1);
        miss(10'h2A4, 4'b0010, 0, 4, 8'h00, 0, -1, 1'b1, dt);
        chk("latency_after_abort", dt, 6);
        miss(10'h2AC, 4'b0001, 0, 4, 8'h00, 0, -1, 1'b0, dt);
        miss(10'h15B, 4'b1000, 2, 0, 8'h00, 0, -1, 1'b1, dt);
        for (int n = 0; n < 30; n++) begin
            a = 10'($urandom);
            if ($urandom_range(4) == 0) begin
                hit(a, 2);
            end else begin
                la = int'($urandom_range(9));
                la = la > 4 ? 4 : la;
                rs = '0;
                for (int j = 0; j < BEATS; j++) if ($urandom_range(5) == 0) rs[2*j +: 2] = 2'($urandom_range(1, 3));
                miss(a, 4'(1 << $urandom_range(3)), int'($urandom_range(3)), la, rs, 2, -1, 1'b1, dt);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
